// File: rtl/cmd_led_controller.sv
// LED command executor with a valid/ready status/read-back byte stream,
// a blink engine and pulse-stretched UART activity LEDs.
module cmd_led_controller #(
   parameter int unsigned NUM_LEDS       = 8,
   parameter int unsigned CMD_WIDTH      = 32,
   parameter int unsigned STRETCH_CYCLES = 1_000_000,
   parameter int unsigned BLINK_DIV      = 25_000_000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cmd_valid,
   input  logic [7:0]           opcode,
   input  logic [CMD_WIDTH-1:0] command,
   input  logic                 rx_line,
   input  logic                 tx_line,
   input  logic                 tx_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_byte,
   output logic [NUM_LEDS-1:0]  led,
   output logic                 led_rx,
   output logic                 led_tx,
   output logic                 cmd_seen,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned NB   = (NUM_LEDS + 7) / 8;
   localparam int unsigned IDXW = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned PW   = $clog2(BLINK_DIV);
   localparam int unsigned SW   = $clog2(STRETCH_CYCLES + 1);

   localparam logic [7:0] OP_PING  = 8'h00;
   localparam logic [7:0] OP_SET   = 8'h08;
   localparam logic [7:0] OP_OR    = 8'h09;
   localparam logic [7:0] OP_CLR   = 8'h0A;
   localparam logic [7:0] OP_TGL   = 8'h0B;
   localparam logic [7:0] OP_BLINK = 8'h0C;
   localparam logic [7:0] OP_READ  = 8'h0D;

   typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_DATA} state_t;

   state_t              state_q, state_d;
   logic [IDXW-1:0]     idx_q, idx_d;
   logic [NB*8-1:0]     snap_q, snap_d;
   logic                nack_q, nack_d;
   logic                read_q, read_d;
   logic [NUM_LEDS-1:0] led_reg_q, led_reg_d;
   logic [NUM_LEDS-1:0] blink_mask_q, blink_mask_d;
   logic                phase_q, phase_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                cmd_seen_q, cmd_seen_d;
   logic                overrun_q, overrun_d;
   logic [NUM_LEDS-1:0] led_q;
   logic                rx_s1_q, rx_s2_q, tx_s_q;
   logic [SW-1:0]       rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic                led_rx_q, led_tx_q;
   logic [NUM_LEDS-1:0] m;
   logic [NB*8-1:0]     snap_shift;

   assign m = command[NUM_LEDS-1:0];

   if (CMD_WIDTH > NUM_LEDS) begin : g_unused
      logic unused_cmd_bits;
      assign unused_cmd_bits = ^command[CMD_WIDTH-1:NUM_LEDS];
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      snap_d       = snap_q;
      nack_d       = nack_q;
      read_d       = read_q;
      led_reg_d    = led_reg_q;
      blink_mask_d = blink_mask_q;
      cmd_seen_d   = cmd_seen_q;
      overrun_d    = overrun_q;
      phase_d      = phase_q;
      presc_d      = presc_q + 1'b1;
      if (presc_q == PW'(BLINK_DIV - 1)) begin
         presc_d = '0;
         phase_d = ~phase_q;
      end

      // A command arriving while a response is outstanding is dropped outright.
      if (cmd_valid && state_q != IDLE) overrun_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d    = SEND_STATUS;
               cmd_seen_d = 1'b1;
               nack_d     = 1'b0;
               read_d     = 1'b0;
               idx_d      = '0;
               snap_d     = (NB*8)'(led_reg_q);
               case (opcode)
                  OP_PING:  overrun_d = 1'b0;
                  OP_SET:   led_reg_d = m;
                  OP_OR:    led_reg_d = led_reg_q | m;
                  OP_CLR:   led_reg_d = led_reg_q & ~m;
                  OP_TGL:   led_reg_d = led_reg_q ^ m;
                  OP_BLINK: begin
                     blink_mask_d = m;
                     phase_d      = 1'b0;
                     presc_d      = '0;
                  end
                  OP_READ:  read_d = 1'b1;
                  default:  nack_d = 1'b1;
               endcase
            end
         end
         SEND_STATUS: begin
            if (tx_ready) state_d = read_q ? SEND_DATA : IDLE;
         end
         SEND_DATA: begin
            if (tx_ready) begin
               if (idx_q == IDXW'(NB - 1)) state_d = IDLE;
               else                        idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rx_cnt_d = (rx_cnt_q != '0) ? rx_cnt_q - 1'b1 : '0;
      if (!rx_s2_q) rx_cnt_d = SW'(STRETCH_CYCLES);
      tx_cnt_d = (tx_cnt_q != '0) ? tx_cnt_q - 1'b1 : '0;
      if (!tx_s_q) tx_cnt_d = SW'(STRETCH_CYCLES);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         snap_q       <= '0;
         nack_q       <= 1'b0;
         read_q       <= 1'b0;
         led_reg_q    <= '0;
         blink_mask_q <= '0;
         phase_q      <= 1'b0;
         presc_q      <= '0;
         cmd_seen_q   <= 1'b0;
         overrun_q    <= 1'b0;
         led_q        <= '0;
         // Synchronisers reset to the idle-high line level so reset itself
         // does not look like activity.
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         tx_s_q       <= 1'b1;
         rx_cnt_q     <= '0;
         tx_cnt_q     <= '0;
         led_rx_q     <= 1'b0;
         led_tx_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         snap_q       <= snap_d;
         nack_q       <= nack_d;
         read_q       <= read_d;
         led_reg_q    <= led_reg_d;
         blink_mask_q <= blink_mask_d;
         phase_q      <= phase_d;
         presc_q      <= presc_d;
         cmd_seen_q   <= cmd_seen_d;
         overrun_q    <= overrun_d;
         led_q        <= led_reg_q ^ (blink_mask_q & {NUM_LEDS{phase_q}});
         rx_s1_q      <= rx_line;
         rx_s2_q      <= rx_s1_q;
         tx_s_q       <= tx_line;
         rx_cnt_q     <= rx_cnt_d;
         tx_cnt_q     <= tx_cnt_d;
         led_rx_q     <= (rx_cnt_q != '0);
         led_tx_q     <= (tx_cnt_q != '0);
      end
   end

   assign snap_shift = snap_q >> {idx_q, 3'b000};

   always_comb begin
      tx_byte = '0;
      unique case (state_q)
         SEND_STATUS: tx_byte = nack_q ? 8'hEE : 8'hA5;
         SEND_DATA:   tx_byte = snap_shift[7:0];
         default:     tx_byte = '0;
      endcase
   end

   assign tx_valid = (state_q != IDLE);
   assign busy     = (state_q != IDLE);
   assign led      = led_q;
   assign led_rx   = led_rx_q;
   assign led_tx   = led_tx_q;
   assign cmd_seen = cmd_seen_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_cmd_led_controller.sv
// Scoreboard bench for cmd_led_controller: 12 LEDs, fast blink and stretch.
module tb_cmd_led_controller;

   localparam int unsigned NL = 12;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [7:0]    opcode = '0;
   logic [31:0]   command = '0;
   logic          rx_line = 1'b1;
   logic          tx_line = 1'b1;
   logic          tx_ready = 1'b1;
   logic          tx_valid;
   logic [7:0]    tx_byte;
   logic [NL-1:0] led;
   logic          led_rx, led_tx, cmd_seen, overrun, busy;

   cmd_led_controller #(
      .NUM_LEDS(NL), .CMD_WIDTH(32), .STRETCH_CYCLES(10), .BLINK_DIV(4)
   ) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .opcode(opcode),
      .command(command), .rx_line(rx_line), .tx_line(tx_line),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte), .led(led),
      .led_rx(led_rx), .led_tx(led_tx), .cmd_seen(cmd_seen),
      .overrun(overrun), .busy(busy)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [7:0]  sb[$];
   logic [NL-1:0] model = '0;
   logic        held_v = 1'b0;
   logic [7:0]  held_b = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic send(input logic [7:0] op, input logic [31:0] cmd);
      logic [15:0]   snap;
      logic [NL-1:0] mm;
      mm   = cmd[NL-1:0];
      snap = 16'(model);
      sb.push_back((op == 8'h00 || (op >= 8'h08 && op <= 8'h0D)) ? 8'hA5 : 8'hEE);
      if (op == 8'h0D) begin
         sb.push_back(snap[7:0]);
         sb.push_back(snap[15:8]);
      end
      case (op)
         8'h08: model = mm;
         8'h09: model = model | mm;
         8'h0A: model = model & ~mm;
         8'h0B: model = model ^ mm;
         default: ;
      endcase
      cmd_valid = 1'b1;
      opcode    = op;
      command   = cmd;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drop(input logic [7:0] op, input logic [31:0] cmd);
      cmd_valid = 1'b1;
      opcode    = op;
      command   = cmd;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Output side of the scoreboard: pop on every handshake, enforce holding.
   always @(negedge clock) begin
      if (held_v && tx_valid) check_eq("tx_hold", 32'(tx_byte), 32'(held_b));
      if (tx_valid && tx_ready) begin
         if (sb.size() == 0) check_eq("sb_unexpected", 32'(tx_byte), 32'hFFFF_FFFF);
         else check_eq("tx_byte", 32'(tx_byte), 32'(sb.pop_front()));
      end
      held_v = tx_valid && !tx_ready;
      held_b = tx_byte;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [11:0] tbl_cmd [4] = '{12'h0F0, 12'h00F, 12'h081, 12'h0FF};
      logic [7:0]  tbl_op  [4] = '{8'h08, 8'h09, 8'h0A, 8'h0B};
      logic [11:0] tbl_exp [4] = '{12'h0F0, 12'h0FF, 12'h07E, 12'h081};
      logic        exp_b;

      repeat (3) tick();
      reset = 1'b0;
      check_eq("rst_led", 32'(led), 32'd0);
      check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_cmd_seen", 32'(cmd_seen), 32'd0);
      check_eq("rst_overrun", 32'(overrun), 32'd0);
      check_eq("rst_led_rx", 32'(led_rx), 32'd0);
      check_eq("rst_led_tx", 32'(led_tx), 32'd0);

      send(8'h08, 32'h5A);
      check_eq("set_busy", 32'(busy), 32'd1);
      check_eq("set_tx_valid", 32'(tx_valid), 32'd1);
      check_eq("set_cmd_seen", 32'(cmd_seen), 32'd1);
      tick();
      check_eq("set_led", 32'(led), 32'h05A);
      check_eq("set_busy_low", 32'(busy), 32'd0);

      for (int i = 0; i < 4; i++) begin
         send(tbl_op[i], 32'(tbl_cmd[i]));
         tick();
         check_eq("alu_led", 32'(led), 32'(tbl_exp[i]));
      end

      send(8'h08, 32'hFFFF_FABC);
      tick();
      check_eq("set_abc", 32'(led), 32'hABC);
      send(8'h0D, 32'h0);
      for (int i = 0; i < 20 && busy; i++) begin
         tx_ready = ~tx_ready;
         tick();
      end
      tx_ready = 1'b1;
      wait_idle();

      tx_ready = 1'b0;
      send(8'h0D, 32'h0);
      tick();
      tick();
      drop(8'h08, 32'h33);
      check_eq("ovr_set", 32'(overrun), 32'd1);
      check_eq("ovr_busy", 32'(busy), 32'd1);
      tx_ready = 1'b1;
      wait_idle();
      tick();
      check_eq("ovr_led", 32'(led), 32'hABC);
      send(8'h00, 32'h0);
      tick();
      check_eq("ping_clear", 32'(overrun), 32'd0);

      send(8'h0D, 32'h0);
      tick();
      tick();
      drop(8'h08, 32'h33);
      check_eq("lastbyte_busy", 32'(busy), 32'd0);
      check_eq("lastbyte_ovr", 32'(overrun), 32'd1);
      tick();
      check_eq("lastbyte_led", 32'(led), 32'hABC);
      send(8'h00, 32'h0);
      tick();
      check_eq("ping_clear2", 32'(overrun), 32'd0);

      send(8'h08, 32'h00F);
      tick();
      send(8'h0C, 32'h003);
      for (int i = 1; i <= 12; i++) begin
         tick();
         check_eq("blink", 32'(led), (((i - 1) / 4) % 2 == 1) ? 32'h00C : 32'h00F);
      end
      send(8'h0C, 32'h000);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_eq("blink_off", 32'(led), 32'h00F);
      end

      send(8'h7F, 32'hFFF);
      tick();
      check_eq("nack_led", 32'(led), 32'h00F);
      check_eq("nack_busy", 32'(busy), 32'd0);

      rx_line = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         tick();
         if (i == 1) rx_line = 1'b1;
         exp_b = (i >= 3 && i <= 13);
         check_eq("led_rx", 32'(led_rx), 32'(exp_b));
      end
      tx_line = 1'b0;
      for (int i = 0; i <= 14; i++) begin
         tick();
         if (i == 0) tx_line = 1'b1;
         exp_b = (i >= 2 && i <= 11);
         check_eq("led_tx", 32'(led_tx), 32'(exp_b));
      end

      tx_ready = 1'b0;
      send(8'h0D, 32'h0);
      tick();
      reset = 1'b1;
      sb.delete();
      model = '0;
      tick();
      check_eq("rstmid_tx_valid", 32'(tx_valid), 32'd0);
      check_eq("rstmid_busy", 32'(busy), 32'd0);
      check_eq("rstmid_led", 32'(led), 32'd0);
      check_eq("rstmid_cmd_seen", 32'(cmd_seen), 32'd0);
      reset = 1'b0;
      tx_ready = 1'b1;
      tick();

      send(8'h0D, 32'h0);
      wait_idle();
      tick();
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
